// File: rtl/ifm_rd_arb.sv
// ---------------------------------------------------------------------------
// ifm_rd_arb
//   Shares the single read port of the IFM SRAM between the two crdma
//   address streams (ID 0 and ID 1). Arbitration is round-robin but
//   packet-locked: the requester whose first beat wins keeps the port until
//   it presents its last beat. The SRAM address/enable are registered. A tag
//   pipe travels alongside each read and steers the returning data and its
//   first/last markers back to the requester that issued it.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_addrN/firstN/lastN   requester N beat: address and packet markers
//   req_validN / req_readyN  requester N handshake. A beat transfers in
//                            every cycle where valid and ready are both
//                            high. ready depends combinationally on the
//                            valids and the lock state; the memory side
//                            never back-pressures, so a granted valid beat
//                            is always accepted.
//   mem_addr, mem_en         registered SRAM read address / read enable
//   mem_rdata                SRAM read data, RL cycles after mem_en
//   rd_data                  returned data (shared, equals mem_rdata)
//   rd_validN/firstN/lastN   return markers for requester N (no back-pressure)
//   proto_err                sticky: first beat missing in IDLE, or a first
//                            beat inside a locked packet
//   gnt_cntN                 saturating count of accepted beats per requester
// ---------------------------------------------------------------------------
module ifm_rd_arb #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int DN = 8,
    parameter int RL = 1,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        req_addr0,
    input  logic                 req_first0,
    input  logic                 req_last0,
    input  logic                 req_valid0,
    output logic                 req_ready0,
    input  logic [AW-1:0]        req_addr1,
    input  logic                 req_first1,
    input  logic                 req_last1,
    input  logic                 req_valid1,
    output logic                 req_ready1,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_en,
    input  logic [DN*DW-1:0]     mem_rdata,
    output logic [DN*DW-1:0]     rd_data,
    output logic                 rd_first0,
    output logic                 rd_last0,
    output logic                 rd_valid0,
    output logic                 rd_first1,
    output logic                 rd_last1,
    output logic                 rd_valid1,
    output logic                 proto_err,
    output logic [CW-1:0]        gnt_cnt0,
    output logic [CW-1:0]        gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic first;
        logic last;
    } tag_t;

    state_t        state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic          proto_err_q, proto_err_d;

    logic          acc;
    logic          acc_id;
    logic          acc_first;
    logic          acc_last;
    logic [AW-1:0] acc_addr;

    logic          mem_en_q;
    logic [AW-1:0] mem_addr_q;
    logic          id_q, first_q, last_q;
    tag_t          tag_q [RL];
    tag_t          tag_out;
    logic [CW-1:0] cnt0_q, cnt1_q;

    // Grant / next-state logic
    always_comb begin
        req_ready0  = 1'b0;
        req_ready1  = 1'b0;
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        proto_err_d = proto_err_q;

        unique case (state_q)
            // Tie goes to whoever was not served last.
            IDLE: begin
                req_ready0 = req_valid0 && (!req_valid1 || rr_last_q);
                req_ready1 = req_valid1 && (!req_valid0 || !rr_last_q);
            end
            LOCK0:   req_ready0 = req_valid0;
            LOCK1:   req_ready1 = req_valid1;
            default: ;
        endcase

        acc       = req_ready0 || req_ready1;
        acc_id    = req_ready1;
        acc_first = acc_id ? req_first1 : req_first0;
        acc_last  = acc_id ? req_last1  : req_last0;
        acc_addr  = acc_id ? req_addr1  : req_addr0;

        if (acc) begin
            rr_last_d = acc_id;
            if (state_q == IDLE) begin
                // A headless beat is still served, as a one-beat packet.
                if (!acc_first) proto_err_d = 1'b1;
                else if (!acc_last) state_d = acc_id ? LOCK1 : LOCK0;
            end else begin
                if (acc_first) proto_err_d = 1'b1;
                if (acc_last)  state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            proto_err_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            id_q        <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            for (int i = 0; i < RL; i++) tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            proto_err_q <= proto_err_d;
            mem_en_q    <= acc;
            if (acc) begin
                mem_addr_q <= acc_addr;
                id_q       <= acc_id;
                first_q    <= acc_first;
                last_q     <= acc_last;
            end
            if (acc && !acc_id && cnt0_q != {CW{1'b1}}) cnt0_q <= cnt0_q + CW'(1);
            if (acc &&  acc_id && cnt1_q != {CW{1'b1}}) cnt1_q <= cnt1_q + CW'(1);
            // The tag enters the pipe as the read is issued (mem_en high), so
            // its tail lines up with mem_rdata RL cycles later.
            tag_q[0] <= '{valid: mem_en_q, id: id_q, first: first_q, last: last_q};
            for (int i = 1; i < RL; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out   = tag_q[RL-1];

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign rd_data   = mem_rdata;
    assign rd_valid0 = tag_out.valid && !tag_out.id;
    assign rd_first0 = rd_valid0 && tag_out.first;
    assign rd_last0  = rd_valid0 && tag_out.last;
    assign rd_valid1 = tag_out.valid && tag_out.id;
    assign rd_first1 = rd_valid1 && tag_out.first;
    assign rd_last1  = rd_valid1 && tag_out.last;
    assign proto_err = proto_err_q;
    assign gnt_cnt0  = cnt0_q;
    assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_ifm_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_ifm_rd_arb
//   Two instances share one stimulus stream: d1 (RL=1, CW=16) and d3 (RL=3,
//   CW=3, so its counters saturate quickly). Each requester owns a queue of
//   beats that a driver presents and pops on handshake. The reference model
//   records every accepted beat by cycle number; expected memory and return
//   outputs are then looked up at cycle-1 and cycle-1-RL.
// ---------------------------------------------------------------------------
module tb_ifm_rd_arb;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [13:0] addr;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [13:0] req_addr0 = '0, req_addr1 = '0;
    logic req_first0 = 1'b0, req_last0 = 1'b0, req_valid0 = 1'b0;
    logic req_first1 = 1'b0, req_last1 = 1'b0, req_valid1 = 1'b0;

    logic        d1_ready0, d1_ready1, d1_mem_en, d1_perr;
    logic [13:0] d1_mem_addr;
    logic [63:0] d1_rdata, d1_rd_data;
    logic        d1_f0, d1_l0, d1_v0, d1_f1, d1_l1, d1_v1;
    logic [15:0] d1_cnt0, d1_cnt1;

    logic        d3_ready0, d3_ready1, d3_mem_en, d3_perr;
    logic [13:0] d3_mem_addr;
    logic [63:0] d3_rdata, d3_rd_data;
    logic        d3_f0, d3_l0, d3_v0, d3_f1, d3_l1, d3_v1;
    logic [2:0]  d3_cnt0, d3_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t q0[$];
    beat_t q1[$];

    // Reference model state
    bit          h_v  [0:4095];
    bit          h_id [0:4095];
    bit          h_f  [0:4095];
    bit          h_l  [0:4095];
    bit [13:0]   h_a  [0:4095];
    bit [13:0]   maddr[0:4095];
    int          rst_cyc = -1;
    int          m_owner = -1;
    bit          m_rr = 1'b1;
    bit          m_perr = 1'b0;
    bit          m_er0, m_er1;
    int          ec0a = 0, ec1a = 0, ec0b = 0, ec1b = 0;

    ifm_rd_arb #(.AW(14), .DW(8), .DN(8), .RL(1), .CW(16)) d1 (
        .clk(clk), .rst(rst),
        .req_addr0(req_addr0), .req_first0(req_first0), .req_last0(req_last0),
        .req_valid0(req_valid0), .req_ready0(d1_ready0),
        .req_addr1(req_addr1), .req_first1(req_first1), .req_last1(req_last1),
        .req_valid1(req_valid1), .req_ready1(d1_ready1),
        .mem_addr(d1_mem_addr), .mem_en(d1_mem_en), .mem_rdata(d1_rdata),
        .rd_data(d1_rd_data),
        .rd_first0(d1_f0), .rd_last0(d1_l0), .rd_valid0(d1_v0),
        .rd_first1(d1_f1), .rd_last1(d1_l1), .rd_valid1(d1_v1),
        .proto_err(d1_perr), .gnt_cnt0(d1_cnt0), .gnt_cnt1(d1_cnt1)
    );

    ifm_rd_arb #(.AW(14), .DW(8), .DN(8), .RL(3), .CW(3)) d3 (
        .clk(clk), .rst(rst),
        .req_addr0(req_addr0), .req_first0(req_first0), .req_last0(req_last0),
        .req_valid0(req_valid0), .req_ready0(d3_ready0),
        .req_addr1(req_addr1), .req_first1(req_first1), .req_last1(req_last1),
        .req_valid1(req_valid1), .req_ready1(d3_ready1),
        .mem_addr(d3_mem_addr), .mem_en(d3_mem_en), .mem_rdata(d3_rdata),
        .rd_data(d3_rd_data),
        .rd_first0(d3_f0), .rd_last0(d3_l0), .rd_valid0(d3_v0),
        .rd_first1(d3_f1), .rd_last1(d3_l1), .rd_valid1(d3_v1),
        .proto_err(d3_perr), .gnt_cnt0(d3_cnt0), .gnt_cnt1(d3_cnt1)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM models ----------------
    function automatic logic [63:0] fdat(input logic [13:0] a);
        return {a, 36'h5A5A5A5A5, a};
    endfunction

    logic [63:0] m1_q;
    logic [63:0] m3_q [3];
    always @(posedge clk) begin
        m1_q    <= d1_mem_en ? fdat(d1_mem_addr) : 64'h0;
        m3_q[0] <= d3_mem_en ? fdat(d3_mem_addr) : 64'h0;
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign d1_rdata = m1_q;
    assign d3_rdata = m3_q[2];

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit hv(input int k);
        if (k < 0 || k <= rst_cyc) return 1'b0;
        return h_v[k];
    endfunction

    task automatic cmp_dut(input string nm, input int c, input int r,
                           input logic rdy0, input logic rdy1, input logic me,
                           input logic [13:0] ma, input logic [63:0] rd,
                           input logic v0, input logic f0, input logic l0,
                           input logic v1, input logic f1, input logic l1,
                           input logic pe, input logic [63:0] c0, input logic [63:0] c1,
                           input int ec0, input int ec1);
        int k;
        bit ev, eid, ef, el;
        chk({nm, ".req_ready0"}, 64'(rdy0), 64'(m_er0));
        chk({nm, ".req_ready1"}, 64'(rdy1), 64'(m_er1));
        chk({nm, ".mem_en"}, 64'(me), 64'(hv(c - 1)));
        chk({nm, ".mem_addr"}, 64'(ma), 64'(maddr[c]));
        k   = c - 1 - r;
        ev  = hv(k);
        eid = ev ? h_id[k] : 1'b0;
        ef  = ev ? h_f[k]  : 1'b0;
        el  = ev ? h_l[k]  : 1'b0;
        chk({nm, ".rd_valid0"}, 64'(v0), 64'(ev && !eid));
        chk({nm, ".rd_first0"}, 64'(f0), 64'(ev && !eid && ef));
        chk({nm, ".rd_last0"},  64'(l0), 64'(ev && !eid && el));
        chk({nm, ".rd_valid1"}, 64'(v1), 64'(ev && eid));
        chk({nm, ".rd_first1"}, 64'(f1), 64'(ev && eid && ef));
        chk({nm, ".rd_last1"},  64'(l1), 64'(ev && eid && el));
        if (ev) chk({nm, ".rd_data"}, rd, fdat(h_a[k]));
        chk({nm, ".proto_err"}, 64'(pe), 64'(m_perr));
        chk({nm, ".gnt_cnt0"}, c0, 64'(ec0));
        chk({nm, ".gnt_cnt1"}, c1, 64'(ec1));
    endtask

    // ---------------- model + compare, every cycle ----------------
    always @(negedge clk) begin
        int  c;
        bit  acc, id, af, al;
        bit [13:0] aa;
        c = cyc;
        if (rst) begin
            rst_cyc = c;
            m_owner = -1;
            m_rr    = 1'b1;
            m_perr  = 1'b0;
            ec0a = 0; ec1a = 0; ec0b = 0; ec1b = 0;
            maddr[c] = '0;
        end
        if (m_owner < 0) begin
            m_er0 = req_valid0 && (!req_valid1 || m_rr);
            m_er1 = req_valid1 && (!req_valid0 || !m_rr);
        end else begin
            m_er0 = (m_owner == 0) && req_valid0;
            m_er1 = (m_owner == 1) && req_valid1;
        end

        cmp_dut("d1", c, 1, d1_ready0, d1_ready1, d1_mem_en, d1_mem_addr, d1_rd_data,
                d1_v0, d1_f0, d1_l0, d1_v1, d1_f1, d1_l1, d1_perr,
                64'(d1_cnt0), 64'(d1_cnt1), ec0a, ec1a);
        cmp_dut("d3", c, 3, d3_ready0, d3_ready1, d3_mem_en, d3_mem_addr, d3_rd_data,
                d3_v0, d3_f0, d3_l0, d3_v1, d3_f1, d3_l1, d3_perr,
                64'(d3_cnt0), 64'(d3_cnt1), ec0b, ec1b);

        if (rst) begin
            h_v[c] = 1'b0;
            maddr[c + 1] = '0;
        end else begin
            acc = m_er0 || m_er1;
            id  = m_er1;
            af  = id ? req_first1 : req_first0;
            al  = id ? req_last1  : req_last0;
            aa  = id ? req_addr1  : req_addr0;
            h_v[c] = acc; h_id[c] = id; h_f[c] = af; h_l[c] = al; h_a[c] = aa;
            maddr[c + 1] = acc ? aa : maddr[c];
            if (acc) begin
                if (!id) begin
                    if (ec0a < 65535) ec0a++;
                    if (ec0b < 7)     ec0b++;
                end else begin
                    if (ec1a < 65535) ec1a++;
                    if (ec1b < 7)     ec1b++;
                end
                if (m_owner < 0) begin
                    if (!af)      m_perr  = 1'b1;
                    else if (!al) m_owner = id ? 1 : 0;
                end else begin
                    if (af) m_perr  = 1'b1;
                    if (al) m_owner = -1;
                end
                m_rr = id;
            end
        end
    end

    // ---------------- requester drivers ----------------
    initial begin
        bit a0, a1;
        forever begin
            @(negedge clk);
            a0 = req_valid0 && d1_ready0;
            a1 = req_valid1 && d1_ready1;
            @(posedge clk);
            if (a0 && q0.size() > 0) void'(q0.pop_front());
            if (a1 && q1.size() > 0) void'(q1.pop_front());
            #2;
            if (!rst && q0.size() > 0) begin
                req_valid0 = 1'b1;
                {req_first0, req_last0, req_addr0} = q0[0];
            end else begin
                req_valid0 = 1'b0; req_first0 = 1'b0; req_last0 = 1'b0; req_addr0 = '0;
            end
            if (!rst && q1.size() > 0) begin
                req_valid1 = 1'b1;
                {req_first1, req_last1, req_addr1} = q1[0];
            end else begin
                req_valid1 = 1'b0; req_first1 = 1'b0; req_last1 = 1'b0; req_addr1 = '0;
            end
        end
    end

    task automatic push_pkt(input int who, input logic [13:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.first = (i == 0);
            b.last  = (i == n - 1);
            b.addr  = base + 14'(i);
            if (who == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic push_beat(input int who, input logic f, input logic l, input logic [13:0] a);
        beat_t b;
        b.first = f; b.last = l; b.addr = a;
        if (who == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'(n), 64'(0));
        repeat (8) @(posedge clk);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        q0.delete(); q1.delete();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog t=%0t act=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        bit exp_rdy0 [7];
        bit exp_me   [7];
        bit exp_v    [7];
        bit exp_f    [7];
        bit exp_l    [7];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 4-beat packet from requester 0 at 0x10..0x13
        exp_rdy0 = '{1, 1, 1, 1, 0, 0, 0};
        exp_me   = '{0, 1, 1, 1, 1, 0, 0};
        exp_v    = '{0, 0, 1, 1, 1, 1, 0};
        exp_f    = '{0, 0, 1, 0, 0, 0, 0};
        exp_l    = '{0, 0, 0, 0, 0, 1, 0};
        @(posedge clk); #1;
        push_pkt(0, 14'h10, 4);
        for (int off = 0; off < 7; off++) begin
            @(negedge clk);
            chk("t1_ready0", 64'(d1_ready0), 64'(exp_rdy0[off]));
            chk("t1_mem_en", 64'(d1_mem_en), 64'(exp_me[off]));
            if (off >= 1 && off <= 4) chk("t1_mem_addr", 64'(d1_mem_addr), 64'(14'h10 + 14'(off - 1)));
            chk("t1_rd_valid0", 64'(d1_v0), 64'(exp_v[off]));
            chk("t1_rd_first0", 64'(d1_f0), 64'(exp_f[off]));
            chk("t1_rd_last0",  64'(d1_l0), 64'(exp_l[off]));
        end
        drain();
        chk("t1_gnt_cnt0", 64'(d1_cnt0), 64'd4);
        chk("t1_mem_addr_hold", 64'(d1_mem_addr), 64'h13);

        // Simultaneous 3-beat packets after reset: 0 first, then 1, no gap
        reset_pulse();
        @(posedge clk); #1;
        push_pkt(0, 14'h20, 3);
        push_pkt(1, 14'h30, 3);
        for (int off = 0; off < 7; off++) begin
            @(negedge clk);
            chk("t2_ready0", 64'(d1_ready0), 64'(off < 3));
            chk("t2_ready1", 64'(d1_ready1), 64'(off >= 3 && off < 6));
        end
        drain();
        chk("t2_gnt_cnt1", 64'(d1_cnt1), 64'd3);

        // Back-to-back single-beat packets: grants alternate 0,1,0,1,...
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            push_beat(0, 1'b1, 1'b1, 14'h40 + 14'(i));
            push_beat(1, 1'b1, 1'b1, 14'h50 + 14'(i));
        end
        for (int off = 0; off < 8; off++) begin
            @(negedge clk);
            chk("t3_ready0", 64'(d1_ready0), 64'(off % 2 == 0));
            chk("t3_ready1", 64'(d1_ready1), 64'(off % 2 == 1));
        end
        drain();
        chk("t3_gnt_cnt0", 64'(d1_cnt0), 64'd7);
        chk("t3_gnt_cnt1", 64'(d1_cnt1), 64'd7);
        chk("t3_d3_gnt_cnt0", 64'(d3_cnt0), 64'd7);

        // Headless beat in IDLE, then a first beat inside a lock
        @(posedge clk); #1;
        push_beat(0, 1'b0, 1'b0, 14'h60);
        push_beat(0, 1'b1, 1'b0, 14'h61);
        push_beat(0, 1'b1, 1'b0, 14'h62);
        push_beat(0, 1'b0, 1'b1, 14'h63);
        drain();
        chk("t4_proto_err", 64'(d1_perr), 64'd1);
        chk("t4_d3_proto_err", 64'(d3_perr), 64'd1);
        chk("t4_gnt_cnt0", 64'(d1_cnt0), 64'd11);
        chk("t4_d3_gnt_cnt0_sat", 64'(d3_cnt0), 64'd7);

        // RL=3 alignment: 2-beat packet, returns 4 cycles after each accept
        @(posedge clk); #1;
        push_pkt(0, 14'h70, 2);
        for (int off = 0; off < 7; off++) begin
            @(negedge clk);
            chk("t5_d3_rd_valid0", 64'(d3_v0), 64'(off == 4 || off == 5));
            chk("t5_d3_rd_first0", 64'(d3_f0), 64'(off == 4));
            chk("t5_d3_rd_last0",  64'(d3_l0), 64'(off == 5));
            chk("t5_d3_rd_valid1", 64'(d3_v1), 64'd0);
        end
        drain();

        // Reset while requester 1 is locked with two beats in flight
        @(posedge clk); #1;
        push_pkt(1, 14'h80, 4);
        @(posedge clk);
        @(posedge clk); #1;
        q0.delete(); q1.delete();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int off = 0; off < 5; off++) begin
            @(negedge clk);
            chk("t6_d1_rd_valid1", 64'(d1_v1), 64'd0);
            chk("t6_d3_rd_valid1", 64'(d3_v1), 64'd0);
            chk("t6_mem_en", 64'(d1_mem_en), 64'd0);
        end
        chk("t6_proto_err", 64'(d1_perr), 64'd0);
        chk("t6_gnt_cnt1", 64'(d1_cnt1), 64'd0);
        @(posedge clk); #1;
        push_beat(0, 1'b1, 1'b1, 14'h90);
        push_beat(1, 1'b1, 1'b1, 14'hA0);
        @(negedge clk);
        chk("t6_ready0", 64'(d1_ready0), 64'd1);
        chk("t6_ready1", 64'(d1_ready1), 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifm_rd_arb.md
Name: ifm_rd_arb

Overview:
- Shares one single-port IFM SRAM read port between two crdma address streams (crdma ID 0 and ID 1).
- Packet-locked round-robin arbitration: once a requester's first beat wins, the port stays with it until its last beat.
- A registered address/enable drives the SRAM. A tag pipeline routes read data back to the owning requester, with first/last markers.
- Sits between the crdma ifm_addr0/1 outputs and the IFM buffer read port.

Parameters:
- AW, 14, SRAM word address width.
- DW, 8, element width.
- DN, 8, elements per SRAM word (read data width is DN*DW).
- RL, 1, SRAM read latency in cycles from mem_en to mem_rdata valid (1..4).
- CW, 16, width of the per-requester grant counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_addr0  in  AW  requester 0 address.
- req_first0  in  1  requester 0 first beat of packet.
- req_last0  in  1  requester 0 last beat of packet.
- req_valid0  in  1  requester 0 beat valid.
- req_ready0  out  1  requester 0 beat accepted.
- req_addr1, req_first1, req_last1, req_valid1  in  AW/1/1/1  requester 1 equivalents.
- req_ready1  out  1  requester 1 beat accepted.
- mem_addr  out  AW  SRAM read address (registered).
- mem_en  out  1  SRAM read enable (registered).
- mem_rdata  in  DN*DW  SRAM read data, valid RL cycles after mem_en.
- rd_data  out  DN*DW  returned data, shared by both requesters (equals mem_rdata).
- rd_first0, rd_last0, rd_valid0  out  1 each  return markers for requester 0.
- rd_first1, rd_last1, rd_valid1  out  1 each  return markers for requester 1.
- proto_err  out  1  sticky protocol error flag.
- gnt_cnt0, gnt_cnt1  out  CW each  saturating accepted-beat counters.

Behaviour:
- Reset values: state IDLE; rr_last=1, so requester 0 wins the first tie. All outputs are 0: mem_en, mem_addr, every rd_* valid/first/last, proto_err, both counters, and the whole tag pipe.
- States: IDLE, LOCK0, LOCK1.
- IDLE, arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one that is not rr_last.
  - req_readyN is combinational from the valids and state, and is asserted only for the granted requester. No back-pressure from the memory side: a granted valid beat is always accepted.
- On an accepted beat from requester N: rr_last<=N.
  - first=1, last=0 -> state LOCKN.
  - first=1, last=1 -> stay IDLE (single-beat packet).
  - first=0 while in IDLE -> beat accepted as a single-beat packet, proto_err<=1.
- LOCKN:
  - req_readyN=req_validN; the other requester's ready is forced 0.
  - Accepted beat with last=1 -> IDLE next cycle. There is no bubble: the IDLE cycle arbitrates immediately.
  - Accepted beat with first=1 inside a lock -> proto_err<=1, lock retained.
- Memory side: mem_en<=any accept; mem_addr<=granted address (held when mem_en=0).
- Tag pipe: a shift register of depth RL holding {valid, id, first, last}, loaded in step with mem_en.
  - Tag output valid with id=N -> rd_validN=1; rd_firstN/rd_lastN from the tag; the other requester's markers are 0.
- Latency: accept cycle t -> mem_en at t+1 -> rd_validN at t+1+RL.
- Return stream: data order per requester equals accept order. No return back-pressure (consumer is always ready).
- gnt_cntN increments per accepted beat and saturates at 2^CW-1 (no wrap).
- Reset asserted mid-packet:
  - The lock, tag pipe and in-flight returns are discarded.
  - After release the arbiter starts in IDLE with requester 0 preferred.
- proto_err clears only on reset.

Test Plan:
- Single requester 0, 4-beat packet at addrs 0x10..0x13 (first on beat 0, last on beat 3), RL=1 -> req_ready0 high 4 consecutive cycles; mem_addr 0x10..0x13 on cycles 1..4; rd_valid0 cycles 2..5 with rd_first0 on cycle 2, rd_last0 on cycle 5; gnt_cnt0=4.
- Both requesters start a 3-beat packet simultaneously after reset -> requester 0 served beats cycles 0-2 and requester 1 cycles 3-5 with no gap; req_ready1=0 for cycles 0-2.
- Back-to-back single-beat packets, both always valid -> grants alternate 0,1,0,1 every cycle; rd_valid0/rd_valid1 alternate with first=last=1.
- Requester 0 valid without first in IDLE -> beat accepted, proto_err=1 and stays 1; a later first-inside-lock keeps the lock and proto_err remains 1.
- RL=3 build, 2-beat packet -> rd_valid0 exactly 4 cycles after each accept; tag/id alignment is correct.
- Reset pulsed while LOCK1 with 2 beats in flight -> no rd_valid1 after reset; outputs 0; next simultaneous request grants requester 0. Counter saturation: force gnt_cnt0 to 0xFFFF and accept a beat -> counter stays 0xFFFF.
